// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
//
// Purpose:
//   Byte scheduler in front of a UART transmit serializer that has no
//   busy/ready handshake. Bytes from a producer are buffered in a small FIFO.
//   Each byte is then presented on o_uart_din together with a stretched
//   o_uart_en pulse. Successive pulses are spaced by a full serial frame
//   (start + 8 data + stop) plus GAP_BITS idle bit periods and a small margin,
//   so the serializer is always idle when the next trigger arrives.
//
// Ports:
//   i_sys_clk    in   1      system clock, rising edge
//   i_sys_rst    in   1      asynchronous reset, active low
//   i_wr_en      in   1      producer write strobe, taken only while o_full==0
//   i_wr_data    in   8      byte to queue
//   o_full       out  1      FIFO holds FIFO_DEPTH bytes (registered)
//   o_empty      out  1      FIFO holds no bytes (registered)
//   o_level      out  AW+1   FIFO occupancy (registered)
//   o_busy       out  1      scheduler FSM is not idle
//   o_uart_en    out  1      level trigger to the serializer, EN_HI cycles high
//   o_uart_din   out  8      byte to the serializer, held from LOAD to next LOAD
//
// Optional feature (macro UART_TX_SCHED_STAT_EN):
//   o_ovf        out  1      sticky flag, set by any write dropped while full
//   o_tx_count   out  16     number of bytes issued, wraps at 0xFFFF
//   With the macro undefined these ports and their logic do not exist.
// ---------------------------------------------------------------------------
module uart_tx_sched #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_BITS   = 1
) (
  input  logic                          i_sys_clk,
  input  logic                          i_sys_rst,
  input  logic                          i_wr_en,
  input  logic [7:0]                    i_wr_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_busy,
  output logic                          o_uart_en,
  output logic [7:0]                    o_uart_din
`ifdef UART_TX_SCHED_STAT_EN
  ,
  output logic                          o_ovf,
  output logic [15:0]                   o_tx_count
`endif
);

  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int BAUD_CNT  = CLK_FREQ / BAUD;
  localparam int EN_HI     = 4;
  localparam int FRAME_CYC = BAUD_CNT * (10 + GAP_BITS) + 4;
  localparam int CW        = $clog2(FRAME_CYC + 1);

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] EN_LAST    = CW'(EN_HI - 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CYC - 1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   LVL_ONE    = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_FULL   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_PULSE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_nxt;
  logic          r_full;
  logic          r_empty;

  logic          r_uart_en;
  logic [7:0]    r_uart_din;

  logic          w_wr;
  logic          w_pop;

  // Acceptance uses only the registered full flag, so a pop in the same
  // cycle never frees a slot for a write that arrives while full.
  assign w_wr  = i_wr_en && !r_full;

  // The head byte is popped on the edge that enters LOAD; both entries into
  // LOAD are gated by the registered empty flag.
  assign w_pop = (w_state_nxt == S_LOAD);

  // Next-state logic. r_cnt is shared by PULSE (EN_HI cycles) and WAIT
  // (FRAME_CYC cycles) and restarts from zero on each entry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (!r_empty) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_PULSE;
        w_cnt_nxt   = '0;
      end
      S_PULSE: begin
        if (r_cnt == EN_LAST) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_WAIT: begin
        if (r_cnt == FRAME_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = r_empty ? S_IDLE : S_LOAD;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Occupancy after this edge: a simultaneous write and pop cancel out.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_nxt = r_count + LVL_ONE;
      2'b01:   w_count_nxt = r_count - LVL_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array carries no reset; the pointers define which entries hold data.
  always_ff @(posedge i_sys_clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == LVL_FULL);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Serializer-facing outputs are registered so o_uart_en is glitch-free for
  // the downstream synchronizer and o_uart_din is stable before the trigger.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_uart_en  <= 1'b0;
      r_uart_din <= 8'h00;
    end else begin
      r_uart_en <= (w_state_nxt == S_PULSE);
      if (w_pop) begin
        r_uart_din <= r_mem[r_rptr];
      end
    end
  end

  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_level    = r_count;
  assign o_busy     = (r_state != S_IDLE);
  assign o_uart_en  = r_uart_en;
  assign o_uart_din = r_uart_din;

`ifdef UART_TX_SCHED_STAT_EN
  logic        r_ovf;
  logic [15:0] r_tx_count;

  // Overflow is sticky until reset; the issue counter wraps naturally.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_ovf      <= 1'b0;
      r_tx_count <= 16'h0000;
    end else begin
      if (i_wr_en && r_full) begin
        r_ovf <= 1'b1;
      end
      if (w_pop) begin
        r_tx_count <= r_tx_count + 16'h0001;
      end
    end
  end

  assign o_ovf      = r_ovf;
  assign o_tx_count = r_tx_count;
`endif

endmodule
